gray_count_checker: RTL and testbench
=====================================

// Module: gray_count_checker
// PURPOSE
//  Downstream consumer of the parallel Gray-code counter (gray_in <- count_out).
//  Samples the Gray word, decodes it to binary and checks each step is legal (+1 mod 2^N or hold).
//  Runs a lock FSM (lock after LOCK_CNT consecutive good steps) and keeps a saturating error count.
//  Single clock domain; feeds status/debug logic.
// PARAMETERS
//  N        4  Gray/binary word width (>=2)
//  LOCK_CNT 3  consecutive +1 steps needed to declare lock (>=1)
//  ERR_W    8  width of saturating error counter
// PORTS
//  clk            in   1      rising-edge clock
//  reset_ah_in    in   1      async reset, active high
//  gray_in        in   N      Gray word from upstream counter
//  sample_en_in   in   1      sample gray_in at this edge
//  clear_err_in   in   1      sync clear of err_count_out
//  bin_out        out  N      registered binary of last sample
//  bin_valid_out  out  1      1-cycle pulse: bin_out updated
//  step_err_out   out  1      1-cycle pulse, coincident with bin_valid_out: illegal step
//  locked_out     out  1      high while FSM in S_LOCK
//  err_count_out  out  ERR_W  saturating illegal-step count
// BEHAVIOUR
//  - Reset (async, immediate): all outputs 0, prev binary 0, has_prev 0, good_cnt 0, state S_IDLE.
//    Reset mid-operation aborts any lock progress.
//  - sample_en_in=0: all state holds; bin_valid_out=0, step_err_out=0.
//  - sample_en_in=1 at an edge (latency 1 cycle):
//    - bin_out <= gray2bin(gray_in); bin_valid_out <= 1.
//    - new binary becomes prev.
//  - Step classification (only when has_prev=1):
//    - delta = (new - prev) mod 2^N, N-bit wrap arithmetic.
//    - delta==1: GOOD; includes wrap 2^N-1 -> 0.
//    - delta==0: HOLD; neither error nor progress.
//    - otherwise: ERR, including backward steps.
//    - First sample after reset sets has_prev only; it is not classified.
//  - FSM (state and locked_out update at the same edge as bin_out):
//    - S_IDLE: on sample -> S_ACQ, good_cnt=0.
//    - S_ACQ:
//      - GOOD: good_cnt+1; if it reaches LOCK_CNT -> S_LOCK.
//      - ERR: good_cnt=0, stay.
//      - HOLD: no change.
//    - S_LOCK:
//      - ERR: -> S_ACQ, good_cnt=0.
//      - GOOD/HOLD: stay.
//    - locked_out = (state==S_LOCK).
//  - step_err_out <= (class==ERR) for the sampled edge.
//  - err_count_out:
//    - ERR: +1, saturates at 2^ERR_W-1 (never wraps).
//    - clear_err_in: sets to 0.
//    - clear_err_in and ERR in the same cycle: result is 1.
//  - good_cnt width: $clog2(LOCK_CNT+1).
// STRUCTURE
//  - Shared package gray_pkg:
//    - state encodings S_IDLE=2'd0, S_ACQ=2'd1, S_LOCK=2'd2.
//    - step-class constants GOOD/HOLD/ERR.
//    - function gray2bin.
//  - Sub-module gray_to_bin #(N): combinational decoder, bin[N-1]=g[N-1], bin[i]=bin[i+1]^g[i].
//    Instantiated once on gray_in.
//  - Top holds the sample regs, delta/classifier, FSM and error counter.
// TESTING (N=4, LOCK_CNT=3, ERR_W=8 unless noted)
//  1. Reset
//     - Stimulus: reset_ah_in pulsed mid-lock, between clock edges.
//     - Response: all outputs 0 immediately, no clk needed; next sample gives no step_err.
//  2. Acquire
//     - Stimulus: gray 0000,0001,0011,0010 on 4 consecutive sampled edges.
//     - Response: bin_out 0,1,2,3 one cycle after each sample; locked_out rises with the 4th bin_valid_out.
//  3. Wrap
//     - Stimulus: while locked, gray 1001,1000,0000.
//     - Response: bin 14,15,0; step_err_out stays 0; locked_out stays 1.
//  4. Skip
//     - Stimulus: locked at bin 3 (0010), then gray 0111 (5).
//     - Response: step_err_out pulse; err_count_out=1; locked_out falls on that same edge;
//       relock after 3 more GOOD steps.
//  5. Gating/hold
//     - Stimulus: sample_en_in low 5 cycles, then repeated identical gray words.
//     - Response: bin_valid_out 0 in gaps; HOLD gives no error and no lock progress.
//  6. Saturate/clear
//     - Stimulus: ERR_W=2, 5 illegal steps.
//     - Response: count sticks at 3; clear_err_in with a simultaneous ERR gives 1;
//       clear_err_in alone gives 0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-count checker.
package gray_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GOOD = 2'd0,
        HOLD = 2'd1,
        ERR  = 2'd2
    } step_t;

    // Prefix-XOR decode; widths up to 32 bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/gray_count_checker_gray_to_bin.sv
// Combinational Gray-to-binary decoder, MSB first.
module gray_to_bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    always_comb begin
        bin[N-1] = gray[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_count_checker.sv
// Samples an upstream Gray counter, checks each step and tracks lock.
module gray_count_checker
    import gray_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset_ah_in,
    input  logic [N-1:0]     gray_in,
    input  logic             sample_en_in,
    input  logic             clear_err_in,
    output logic [N-1:0]     bin_out,
    output logic             bin_valid_out,
    output logic             step_err_out,
    output logic             locked_out,
    output logic [ERR_W-1:0] err_count_out
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    logic [N-1:0]  dec_bin;
    logic [N-1:0]  delta;
    logic          has_prev;
    step_t         cls;
    logic          step_err;
    state_t        state;
    logic [GW-1:0] good_cnt;
    logic [GW-1:0] good_inc;

    gray_to_bin #(.N(N)) u_dec (
        .gray (gray_in),
        .bin  (dec_bin)
    );

    // bin_out doubles as the previous sample for the step check.
    assign delta    = dec_bin - bin_out;
    assign good_inc = good_cnt + 1'b1;
    assign step_err = sample_en_in && (cls == ERR);

    always_comb begin
        cls = HOLD;
        if (has_prev) begin
            unique case (1'b1)
                (delta == N'(1)): cls = GOOD;
                (delta == '0):    cls = HOLD;
                default:          cls = ERR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            bin_out       <= '0;
            bin_valid_out <= 1'b0;
            step_err_out  <= 1'b0;
            has_prev      <= 1'b0;
        end else begin
            bin_valid_out <= sample_en_in;
            step_err_out  <= step_err;
            if (sample_en_in) begin
                bin_out  <= dec_bin;
                has_prev <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            state      <= S_IDLE;
            good_cnt   <= '0;
            locked_out <= 1'b0;
        end else if (sample_en_in) begin
            unique case (state)
                S_IDLE: begin
                    state    <= S_ACQ;
                    good_cnt <= '0;
                end
                S_ACQ: begin
                    if (cls == GOOD) begin
                        good_cnt <= good_inc;
                        if (good_inc == GW'(LOCK_CNT)) begin
                            state      <= S_LOCK;
                            locked_out <= 1'b1;
                        end
                    end else if (cls == ERR) begin
                        good_cnt <= '0;
                    end
                end
                S_LOCK: begin
                    if (cls == ERR) begin
                        state      <= S_ACQ;
                        good_cnt   <= '0;
                        locked_out <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    good_cnt   <= '0;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

    // A clear that coincides with an error keeps that error.
    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            err_count_out <= '0;
        end else if (clear_err_in) begin
            err_count_out <= step_err ? ERR_W'(1) : '0;
        end else if (step_err && (err_count_out != '1)) begin
            err_count_out <= err_count_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_gray_count_checker.sv
// Directed bench with a behavioural step/lock/count model.
module tb_gray_count_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gray;
    logic       en;
    logic       clr;

    logic [3:0] a_bin, b_bin;
    logic       a_val, b_val, a_err, b_err, a_lck, b_lck;
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;

    int checks = 0;
    int passed = 0;
    bit run = 1'b0;

    int m_bin, m_val, m_err, m_lck, m_cnt8, m_cnt2;
    int m_has, m_started, m_gc;

    always #5 clk = ~clk;

    gray_count_checker #(.N(4), .LOCK_CNT(3), .ERR_W(8)) dut_a (
        .clk           (clk),
        .reset_ah_in   (rst),
        .gray_in       (gray),
        .sample_en_in  (en),
        .clear_err_in  (clr),
        .bin_out       (a_bin),
        .bin_valid_out (a_val),
        .step_err_out  (a_err),
        .locked_out    (a_lck),
        .err_count_out (a_cnt)
    );

    gray_count_checker #(.N(4), .LOCK_CNT(3), .ERR_W(2)) dut_b (
        .clk           (clk),
        .reset_ah_in   (rst),
        .gray_in       (gray),
        .sample_en_in  (en),
        .clear_err_in  (clr),
        .bin_out       (b_bin),
        .bin_valid_out (b_val),
        .step_err_out  (b_err),
        .locked_out    (b_lck),
        .err_count_out (b_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: decode by XOR of all higher Gray bits, classify by mod-16 delta.
    always @(posedge clk or posedge rst) begin
        logic [3:0] g;
        int nb, d, bad, good;
        if (rst) begin
            m_bin = 0; m_val = 0; m_err = 0; m_lck = 0;
            m_cnt8 = 0; m_cnt2 = 0;
            m_has = 0; m_started = 0; m_gc = 0;
        end else begin
            bad = 0;
            good = 0;
            m_val = en;
            if (en) begin
                g = gray;
                nb = 0;
                for (int i = 0; i < 4; i++) nb |= int'(^(g >> i)) << i;
                if (m_has != 0) begin
                    d = (nb - m_bin + 16) % 16;
                    good = (d == 1);
                    bad = (d != 0) && (d != 1);
                end
                if (m_started == 0) begin
                    m_started = 1;
                    m_gc = 0;
                end else if (bad != 0) begin
                    m_gc = 0;
                    m_lck = 0;
                end else if (good != 0 && m_lck == 0) begin
                    m_gc++;
                    if (m_gc == 3) m_lck = 1;
                end
                m_bin = nb;
                m_has = 1;
            end
            m_err = bad;
            if (clr) begin
                m_cnt8 = bad;
                m_cnt2 = bad;
            end else if (bad != 0) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    end

    always @(negedge clk) begin
        if (run && !rst) begin
            chk("bin_a", a_bin, m_bin);
            chk("valid_a", a_val, m_val);
            chk("err_a", a_err, m_err);
            chk("lock_a", a_lck, m_lck);
            chk("cnt_a", a_cnt, m_cnt8);
            chk("bin_b", b_bin, m_bin);
            chk("valid_b", b_val, m_val);
            chk("err_b", b_err, m_err);
            chk("lock_b", b_lck, m_lck);
            chk("cnt_b", b_cnt, m_cnt2);
        end
    end

    task automatic samp(input int b);
        logic [3:0] v;
        v = 4'(b);
        gray = v ^ (v >> 1);
        en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; gray = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_bin", a_bin, 0);
        chk("rst_valid", a_val, 0);
        chk("rst_lock", a_lck, 0);
        chk("rst_cnt", a_cnt, 0);
        run = 1'b1;

        samp(0); samp(1); samp(2); samp(3);
        chk("acq_bin", a_bin, 3);
        chk("acq_lock", a_lck, 1);

        samp(5);
        chk("skip_err", a_err, 1);
        chk("skip_cnt", a_cnt, 1);
        chk("skip_lock", a_lck, 0);
        samp(6); samp(7);
        chk("relock_early", a_lck, 0);
        samp(8);
        chk("relock", a_lck, 1);

        for (int b = 9; b <= 15; b++) samp(b);
        chk("wrap_bin15", a_bin, 15);
        samp(0);
        chk("wrap_bin0", a_bin, 0);
        chk("wrap_err", a_err, 0);
        chk("wrap_lock", a_lck, 1);

        idle(5);
        chk("gap_valid", a_val, 0);
        samp(0); samp(0);
        chk("hold_err", a_err, 0);
        chk("hold_lock", a_lck, 1);

        samp(5);
        chk("hold_skip_cnt", a_cnt, 2);
        samp(5); samp(5); samp(5);
        samp(6); samp(7);
        chk("hold_noprog", a_lck, 0);
        samp(8);
        chk("hold_relock", a_lck, 1);

        samp(0); samp(8); samp(0); samp(8); samp(0);
        chk("sat_cnt_b", b_cnt, 3);
        chk("sat_cnt_a", a_cnt, 7);
        clr = 1'b1;
        samp(8);
        chk("clr_err_b", b_cnt, 1);
        chk("clr_err_a", a_cnt, 1);
        idle(1);
        clr = 1'b0;
        chk("clr_b", b_cnt, 0);
        chk("clr_a", a_cnt, 0);

        samp(9); samp(10); samp(11);
        chk("pre_rst_lock", a_lck, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_lock", a_lck, 0);
        chk("mid_rst_bin", a_bin, 0);
        chk("mid_rst_valid", a_val, 0);
        chk("mid_rst_lock_b", b_lck, 0);
        #1 rst = 1'b0;
        samp(7);
        chk("post_rst_bin", a_bin, 7);
        chk("post_rst_err", a_err, 0);
        samp(12);
        chk("post_rst_skip", a_cnt, 1);
        idle(2);
        run = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
